// File: rtl/cpu_port_bridge_pkg.sv
// Shared definitions for the 65xx CPU-socket bridge.
//   - Register offsets inside the two-byte on-chip I/O port window.
//   - Port/fade mask presets for the 7501/8501 and 6510 families.
//   - Width helper for the per-bit fade counters.
package cpu_port_bridge_pkg;

  localparam logic PORT_DATA_OFS = 1'b0;
  localparam logic PORT_DDR_OFS  = 1'b1;

  // 7501/8501: bit 5 has no pin.
  localparam logic [7:0] PIO_MASK_7501  = 8'hDF;
  // No fade emulation / 6510-style fade on the two upper (unbonded) bits.
  localparam logic [7:0] FADE_MASK_NONE = 8'h00;
  localparam logic [7:0] FADE_MASK_6510 = 8'hC0;

  // Counter must be able to hold the value FADE_CYCLES itself.
  function automatic int fade_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/cpu_port_bridge_if.sv
// Bus bundle between host 65xx core, bridge and external CPU socket.
// Bidirectional pins (data_cpu, data_ext, pio) are carried as separate
// input / output / output-enable vectors; the pad ring builds the actual
// tri-state buffers, so "Z" on a pin means its _oe is 0.
//   Host side : r_w_cpu, address_cpu, data_cpu_i/_o/_oe, aec, gate_in
//   Socket    : r_w_ext(_oe), address_ext(_oe), data_ext_i/_o/_oe
//   I/O port  : pio_i (pin level), pio_o, pio_oe (per bit)
// modport master: the environment (host core + socket + port pins).
// modport slave : the bridge.
interface cpu_port_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);

  logic                  r_w_cpu;
  logic [ADDR_WIDTH-1:0] address_cpu;
  logic [DATA_WIDTH-1:0] data_cpu_i;
  logic [DATA_WIDTH-1:0] data_cpu_o;
  logic                  data_cpu_oe;
  logic                  aec;
  logic                  gate_in;

  logic                  r_w_ext;
  logic                  r_w_ext_oe;
  logic [ADDR_WIDTH-1:0] address_ext;
  logic                  address_ext_oe;
  logic [DATA_WIDTH-1:0] data_ext_i;
  logic [DATA_WIDTH-1:0] data_ext_o;
  logic                  data_ext_oe;

  logic [DATA_WIDTH-1:0] pio_i;
  logic [DATA_WIDTH-1:0] pio_o;
  logic [DATA_WIDTH-1:0] pio_oe;

  modport master (
    output r_w_cpu, address_cpu, data_cpu_i, aec, gate_in, data_ext_i, pio_i,
    input  data_cpu_o, data_cpu_oe, r_w_ext, r_w_ext_oe, address_ext,
           address_ext_oe, data_ext_o, data_ext_oe, pio_o, pio_oe
  );

  modport slave (
    input  r_w_cpu, address_cpu, data_cpu_i, aec, gate_in, data_ext_i, pio_i,
    output data_cpu_o, data_cpu_oe, r_w_ext, r_w_ext_oe, address_ext,
           address_ext_oe, data_ext_o, data_ext_oe, pio_o, pio_oe
  );

endinterface

// File: rtl/cpu_port_bridge_fade.sv
// port_fade_cell: one floating-bit fade emulator for a single port bit.
// When the bit's direction goes output -> input, the last driven value is
// remembered and read back for FADE_CYCLES clocks, then decays to 0.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   ddr_we_i        DDR register write strobe this clock
//   ddr_old_i       current DDR bit
//   ddr_new_i       DDR bit being written
//   port_bit_i      current port data register bit
//   fade_val_o      remembered value
//   active_o        fade in progress (counter non-zero)
module port_fade_cell
  import cpu_port_bridge_pkg::*;
#(
  parameter int FADE_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ddr_we_i,
  input  logic ddr_old_i,
  input  logic ddr_new_i,
  input  logic port_bit_i,
  output logic fade_val_o,
  output logic active_o
);

  localparam int            CW   = fade_cnt_width(FADE_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(FADE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          val_q, val_d;

  // A new output->input transition takes priority over expiry, so a reload
  // on the same clock the old fade runs out still starts a full fade.
  always_comb begin
    cnt_d = cnt_q;
    val_d = val_q;
    if (ddr_we_i && ddr_old_i && !ddr_new_i) begin
      cnt_d = LOAD;
      val_d = port_bit_i;
    end else if (ddr_we_i && !ddr_old_i && ddr_new_i) begin
      cnt_d = '0;
      val_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) val_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      val_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      val_q <= val_d;
    end
  end

  assign fade_val_o = val_q;
  assign active_o   = (cnt_q != '0);

endmodule

// File: rtl/cpu_port_bridge.sv
// cpu_port_bridge: passes the host 65xx bus through to an external CPU
// socket while AEC is high and emulates the on-chip I/O port (data register
// at BASE_ADDR, DDR at BASE_ADDR+1) of 7501/8501/6510-class parts.
// Ports:
//   clock    system clock (phi2 domain), all state on rising edge
//   _reset   asynchronous active-low reset
//   bus      cpu_port_bridge_if.slave: host bus, socket bus, port pins
// BASE_ADDR is expected to be even: bit 0 of the host address selects
// data register vs DDR.
module cpu_port_bridge
  import cpu_port_bridge_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h0000,
  parameter logic [DATA_WIDTH-1:0] PIO_MASK    = PIO_MASK_7501,
  parameter logic [DATA_WIDTH-1:0] ABSENT_VAL  = 8'h00,
  parameter logic [DATA_WIDTH-1:0] FADE_MASK   = FADE_MASK_NONE,
  parameter int                    FADE_CYCLES = 4096
) (
  input logic               clock,
  input logic               _reset,
  cpu_port_bridge_if.slave  bus
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic          ce_port;
  logic          port_we;
  logic          data_we;
  logic          ddr_we;
  logic [DW-1:0] wdata;

  logic [DW-1:0] port_data_q, port_data_d;
  logic [DW-1:0] ddr_q, ddr_d;
  logic          rw_latched_q, rw_latched_d;
  logic [DW-1:0] pio_meta_q;
  logic [DW-1:0] pio_s_q;

  logic [DW-1:0] fade_val;
  logic [DW-1:0] fade_active;
  logic [DW-1:0] port_rd;
  logic [DW-1:0] ddr_rd;

  // Address decode: two-byte window, aec qualifies every port access.
  assign ce_port = bus.aec && (bus.address_cpu[AW-1:1] == BASE_ADDR[AW-1:1]);
  assign port_we = ce_port && !bus.r_w_cpu;
  assign data_we = port_we && (bus.address_cpu[0] == PORT_DATA_OFS);
  assign ddr_we  = port_we && (bus.address_cpu[0] == PORT_DDR_OFS);
  // Absent bits are never stored, so they can never be driven.
  assign wdata   = bus.data_cpu_i & PIO_MASK;

  always_comb begin
    port_data_d  = port_data_q;
    ddr_d        = ddr_q;
    rw_latched_d = rw_latched_q;
    if (data_we)     port_data_d  = wdata;
    if (ddr_we)      ddr_d        = wdata;
    if (bus.gate_in) rw_latched_d = bus.r_w_cpu;
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      port_data_q  <= '0;
      ddr_q        <= '0;
      rw_latched_q <= 1'b1;
      pio_meta_q   <= '0;
      pio_s_q      <= '0;
    end else begin
      port_data_q  <= port_data_d;
      ddr_q        <= ddr_d;
      rw_latched_q <= rw_latched_d;
      pio_meta_q   <= bus.pio_i;
      pio_s_q      <= pio_meta_q;
    end
  end

  for (genvar i = 0; i < DW; i++) begin : g_bit
    if (FADE_MASK[i]) begin : g_fade
      port_fade_cell #(
        .FADE_CYCLES (FADE_CYCLES)
      ) u_fade (
        .clk_i      (clock),
        .rst_ni     (_reset),
        .ddr_we_i   (ddr_we),
        .ddr_old_i  (ddr_q[i]),
        .ddr_new_i  (wdata[i]),
        .port_bit_i (port_data_q[i]),
        .fade_val_o (fade_val[i]),
        .active_o   (fade_active[i])
      );
    end else begin : g_nofade
      assign fade_val[i]    = 1'b0;
      assign fade_active[i] = 1'b0;
    end
  end

  // Per-bit read priority: absent > output > fading input > synchronised pin.
  assign port_rd = (PIO_MASK & ((ddr_q & port_data_q)
                              | (~ddr_q & fade_active & fade_val)
                              | (~ddr_q & ~fade_active & pio_s_q)))
                 | (~PIO_MASK & ABSENT_VAL);
  assign ddr_rd  = (ddr_q & PIO_MASK) | (ABSENT_VAL & ~PIO_MASK);

  // Socket side: everything released when the host does not own the bus.
  assign bus.r_w_ext        = bus.gate_in ? bus.r_w_cpu : rw_latched_q;
  assign bus.r_w_ext_oe     = bus.aec;
  assign bus.address_ext    = bus.address_cpu;
  assign bus.address_ext_oe = bus.aec;
  // Port writes stay internal; only non-port writes reach the socket.
  assign bus.data_ext_o     = bus.data_cpu_i;
  assign bus.data_ext_oe    = bus.aec && !ce_port && !bus.r_w_cpu;

  // Host side read data: internal registers or socket data.
  assign bus.data_cpu_o     = ce_port ? (bus.address_cpu[0] ? ddr_rd : port_rd)
                                      : bus.data_ext_i;
  assign bus.data_cpu_oe    = bus.aec && bus.r_w_cpu;

  assign bus.pio_o          = port_data_q;
  assign bus.pio_oe         = ddr_q;

endmodule

// File: tb/tb_cpu_port_bridge.sv
// Self-checking bench for cpu_port_bridge (7501 port mask, 6510-style fade
// on bits 7:6, short fade time). A behavioural model tracks register
// contents, pin history and fade expiry times in clock counts.
module tb_cpu_port_bridge;
  import cpu_port_bridge_pkg::*;

  localparam int         AW    = 16;
  localparam int         DW    = 8;
  localparam logic [7:0] PMASK = PIO_MASK_7501;
  localparam logic [7:0] FMASK = FADE_MASK_6510;
  localparam logic [7:0] ABSV  = 8'h00;
  localparam int         FCYC  = 8;

  logic clock = 1'b0;
  logic _reset;
  always #5 clock = ~clock;

  cpu_port_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cpu_port_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BASE_ADDR  (16'h0000),
    .PIO_MASK   (PMASK),
    .ABSENT_VAL (ABSV),
    .FADE_MASK  (FMASK),
    .FADE_CYCLES(FCYC)
  ) dut (
    .clock  (clock),
    ._reset (_reset),
    .bus    (bus)
  );

  // External world on the port pins: driven bits follow the bridge.
  logic [7:0] ext_pio;
  assign bus.pio_i = (bus.pio_oe & bus.pio_o) | (~bus.pio_oe & ext_pio);

  // Reference model state
  logic [7:0] m_data, m_ddr, m_s1, m_s2, m_fval;
  logic       m_rwl;
  int         m_cyc;
  int         m_fend [8];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_ddr = 8'h00; m_s1 = 8'h00; m_s2 = 8'h00;
    m_fval = 8'h00; m_rwl = 1'b1;
    foreach (m_fend[i]) m_fend[i] = 0;
  endtask

  // Called at each rising edge with the pre-edge inputs still applied.
  task automatic model_edge();
    logic [7:0] pin, w;
    m_cyc++;
    if (!_reset) begin
      model_reset();
      return;
    end
    pin  = (m_ddr & m_data) | (~m_ddr & ext_pio);
    m_s2 = m_s1;
    m_s1 = pin;
    if (bus.gate_in) m_rwl = bus.r_w_cpu;
    if (bus.aec && bus.address_cpu[15:1] == 15'd0 && !bus.r_w_cpu) begin
      w = bus.data_cpu_i & PMASK;
      if (bus.address_cpu[0]) begin
        for (int i = 0; i < 8; i++) begin
          if (FMASK[i] && m_ddr[i] && !w[i]) begin
            m_fend[i] = m_cyc + FCYC;
            m_fval[i] = m_data[i];
          end else if (FMASK[i] && !m_ddr[i] && w[i]) begin
            m_fend[i] = 0;
          end
        end
        m_ddr = w;
      end else begin
        m_data = w;
      end
    end
  endtask

  function automatic logic [7:0] exp_port_rd();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if (!PMASK[i])                          r[i] = ABSV[i];
      else if (m_ddr[i])                      r[i] = m_data[i];
      else if (FMASK[i] && m_cyc < m_fend[i]) r[i] = m_fval[i];
      else                                    r[i] = m_s2[i];
    end
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    logic       ce, wr_ext;
    logic [7:0] rd;
    ce     = bus.aec && (bus.address_cpu[15:1] == 15'd0);
    wr_ext = bus.aec && !ce && !bus.r_w_cpu;
    chk({tag, ".rw_oe"}, 32'(bus.r_w_ext_oe), 32'(bus.aec));
    chk({tag, ".ad_oe"}, 32'(bus.address_ext_oe), 32'(bus.aec));
    if (bus.aec) begin
      chk({tag, ".rw"}, 32'(bus.r_w_ext), 32'(bus.gate_in ? bus.r_w_cpu : m_rwl));
      chk({tag, ".addr"}, 32'(bus.address_ext), 32'(bus.address_cpu));
    end
    chk({tag, ".dext_oe"}, 32'(bus.data_ext_oe), 32'(wr_ext));
    if (wr_ext) chk({tag, ".dext"}, 32'(bus.data_ext_o), 32'(bus.data_cpu_i));
    chk({tag, ".dcpu_oe"}, 32'(bus.data_cpu_oe), 32'(bus.aec && bus.r_w_cpu));
    if (bus.aec && bus.r_w_cpu) begin
      if (!ce)                     rd = bus.data_ext_i;
      else if (bus.address_cpu[0]) rd = (m_ddr & PMASK) | (ABSV & ~PMASK);
      else                         rd = exp_port_rd();
      chk({tag, ".dcpu"}, 32'(bus.data_cpu_o), 32'(rd));
    end
    chk({tag, ".pio_oe"}, 32'(bus.pio_oe), 32'(m_ddr));
    chk({tag, ".pio"}, 32'(bus.pio_o & m_ddr), 32'(m_data & m_ddr));
  endtask

  task automatic set_in(input logic a_aec, input logic a_rw, input logic [15:0] a_addr,
                        input logic [7:0] a_data, input logic a_gate);
    bus.aec = a_aec; bus.r_w_cpu = a_rw; bus.address_cpu = a_addr;
    bus.data_cpu_i = a_data; bus.gate_in = a_gate;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic settle(input string tag);
    #1;
    check_outputs(tag);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input string tag);
    set_in(1'b1, 1'b0, a, d, 1'b1);
    settle(tag);
    step();
    set_in(1'b1, 1'b1, 16'h8000, 8'h00, 1'b1);
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [7:0] exp, input string tag);
    set_in(1'b1, 1'b1, a, 8'h00, 1'b1);
    settle(tag);
    chk({tag, ".dir"}, 32'(bus.data_cpu_o), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    _reset = 1'b0;
    ext_pio = 8'h00;
    bus.data_ext_i = 8'h3C;
    m_cyc = 0;
    model_reset();
    set_in(1'b1, 1'b0, 16'h8000, 8'h00, 1'b0);

    // Reset state
    step(); step();
    settle("t1_rst");
    chk("t1_rwlatch", 32'(bus.r_w_ext), 32'(1'b1));
    _reset = 1'b1;
    set_in(1'b1, 1'b1, 16'h8000, 8'h00, 1'b1);
    step();
    rd_chk(16'h0000, 8'h00, "t1_port");
    rd_chk(16'h0001, 8'h00, "t1_ddr");
    chk("t1_pio_oe", 32'(bus.pio_oe), 32'(8'h00));
    chk("t1_rw_ext", 32'(bus.r_w_ext), 32'(1'b1));

    // Output port
    wr(16'h0001, 8'hFF, "t2_ddr");
    wr(16'h0000, 8'hA5, "t2_data");
    chk("t2_pio_oe", 32'(bus.pio_oe), 32'(8'hDF));
    chk("t2_pio", 32'(bus.pio_o), 32'(8'h85));
    rd_chk(16'h0000, 8'h85, "t2_rb");
    rd_chk(16'h0001, 8'hDF, "t2_ddr_rb");

    // Input synchronisation
    wr(16'h0001, 8'h00, "t3_ddr");
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, 1'b1, 16'h0000, 8'h00, 1'b1);
      settle("t3_wait");
      step();
    end
    ext_pio = 8'h1F;
    rd_chk(16'h0000, 8'h00, "t3_c0");
    step();
    rd_chk(16'h0000, 8'h00, "t3_c1");
    step();
    rd_chk(16'h0000, 8'h1F, "t3_c2");

    // Fade of bits 7:6
    wr(16'h0000, 8'hC0, "t4_data");
    wr(16'h0001, 8'hC0, "t4_ddr_on");
    chk("t4_pio_oe", 32'(bus.pio_oe), 32'(8'hC0));
    wr(16'h0001, 8'h00, "t4_ddr_off");
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, 1'b1, 16'h0000, 8'h00, 1'b1);
      settle("t4_fade");
      chk("t4_fade_bits", 32'(bus.data_cpu_o & 8'hC0), 32'((k < FCYC) ? 8'hC0 : 8'h00));
      step();
    end
    wr(16'h0001, 8'hC0, "t4_rearm");
    wr(16'h0001, 8'h00, "t4_off2");
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b1, 16'h0000, 8'h00, 1'b1);
      settle("t4_mid");
      step();
    end
    wr(16'h0001, 8'hC0, "t4_cancel");
    chk("t4_cancel_oe", 32'(bus.pio_oe), 32'(8'hC0));
    chk("t4_cancel_pio", 32'(bus.pio_o & 8'hC0), 32'(8'hC0));
    rd_chk(16'h0000, 8'hDF, "t4_cancel_rd");
    for (int k = 0; k < 10; k++) begin
      settle("t4_after");
      step();
    end

    // Passthrough, R/W gating, bus release
    set_in(1'b1, 1'b0, 16'h1234, 8'h5A, 1'b1);
    settle("t5_wr");
    chk("t5_dext", 32'(bus.data_ext_o), 32'(8'h5A));
    chk("t5_dext_oe", 32'(bus.data_ext_oe), 32'(1'b1));
    chk("t5_addr", 32'(bus.address_ext), 32'(16'h1234));
    step();
    bus.gate_in = 1'b0;
    bus.r_w_cpu = 1'b1;
    settle("t5_g0");
    chk("t5_hold1", 32'(bus.r_w_ext), 32'(1'b0));
    step();
    bus.r_w_cpu = 1'b0;
    settle("t5_g1");
    bus.r_w_cpu = 1'b1;
    settle("t5_g2");
    chk("t5_hold2", 32'(bus.r_w_ext), 32'(1'b0));
    step();
    bus.aec = 1'b0;
    settle("t5_aec0");
    chk("t5_z_addr", 32'(bus.address_ext_oe), 32'(1'b0));
    chk("t5_z_dext", 32'(bus.data_ext_oe), 32'(1'b0));
    chk("t5_z_rw", 32'(bus.r_w_ext_oe), 32'(1'b0));
    chk("t5_z_dcpu", 32'(bus.data_cpu_oe), 32'(1'b0));
    step();
    set_in(1'b1, 1'b1, 16'h8000, 8'h00, 1'b1);
    step();

    // Asynchronous reset during a fade with pins driven
    wr(16'h0000, 8'hFF, "t6_data");
    wr(16'h0001, 8'hFF, "t6_ddr");
    wr(16'h0001, 8'h3F, "t6_fade");
    ext_pio = 8'hC0;
    step(); step();
    rd_chk(16'h0000, 8'hDF, "t6_pre");
    #2;
    _reset = 1'b0;
    model_reset();
    #1;
    chk("t6_pio_oe", 32'(bus.pio_oe), 32'(8'h00));
    chk("t6_rd", 32'(bus.data_cpu_o), 32'(8'h00));
    check_outputs("t6_rst");
    step(); step();
    _reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle("t6_post");
      step();
    end

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      case ($urandom_range(0, 5))
        0: a = 16'h0000;
        1: a = 16'h0001;
        2: a = 16'h0002;
        3: a = 16'h0003;
        default: a = 16'($urandom);
      endcase
      set_in(1'($urandom_range(0, 99) < 90), 1'($urandom_range(0, 1)), a,
             8'($urandom), 1'($urandom_range(0, 9) != 0));
      if ($urandom_range(0, 7) == 0) ext_pio = 8'($urandom);
      bus.data_ext_i = 8'($urandom);
      settle("rnd");
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
